// File: rtl/cache_meta_ram.sv
// Per-line metadata store (valid, dirty, tag) for a direct-mapped cache, with
// combinational lookup/compare, one write/invalidate port and a flush sweeper.
module cache_meta_ram #(
  parameter int INDEX_W    = 10,
  parameter int TAG_W      = 20,
  parameter int FLUSH_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               hit,
  input  logic               w_en,
  input  logic               inv_en,
  input  logic [INDEX_W-1:0] w_idx,
  input  logic [TAG_W-1:0]   w_tag,
  input  logic               w_dirty,
  input  logic               flush_req,
  output logic               busy,
  output logic               flush_done,
  output logic [INDEX_W:0]   valid_cnt
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int CNT_W = INDEX_W + 1;
  localparam logic [INDEX_W-1:0] STEP     = INDEX_W'(FLUSH_STEP);
  localparam logic [INDEX_W-1:0] LAST_PTR = INDEX_W'(DEPTH - FLUSH_STEP);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               wr_fill, wr_inv;
  logic [DEPTH-1:0]   clr_mask;

  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q [DEPTH];

  // Lookup path: raw array contents always visible, hit suppressed while sweeping.
  assign valid_o    = valid_q[rd_idx];
  assign dirty_o    = dirty_q[rd_idx];
  assign tag_o      = tag_q[rd_idx];
  assign busy       = (state_q == SWEEP);
  assign hit        = valid_o & (tag_o == rd_tag) & ~busy;
  assign flush_done = done_q;
  assign valid_cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    wr_fill  = 1'b0;
    wr_inv   = 1'b0;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        // Invalidate wins over a simultaneous fill.
        wr_inv  = inv_en;
        wr_fill = w_en & ~inv_en;
        if (wr_inv && valid_q[w_idx]) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (wr_fill && !valid_q[w_idx]) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (flush_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        for (int k = 0; k < FLUSH_STEP; k++) begin
          clr_mask[ptr_q + INDEX_W'(k)] = 1'b1;
        end
        ptr_d = ptr_q + STEP;
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = SWEEP;
        ptr_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Contents are not reset; the sweep that follows reset clears valid/dirty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= valid_q & ~clr_mask;
      dirty_q <= dirty_q & ~clr_mask;
      if (wr_inv) begin
        valid_q[w_idx] <= 1'b0;
        dirty_q[w_idx] <= 1'b0;
      end else if (wr_fill) begin
        valid_q[w_idx] <= 1'b1;
        dirty_q[w_idx] <= w_dirty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_fill) begin
      tag_q[w_idx] <= w_tag;
    end
  end

endmodule
